// File: rtl/sap_control_sequencer.sv
// sap_control_sequencer: micro-step counter and control-word decode for the 8-bit SAP CPU.
// Registered state is the micro-step (T0..T4) and a sticky halted flag; every strobe is
// a combinational decode of step, opcode, halted and (optionally) the ALU flags.
// Optional feature macro: COND_JUMP_EN adds JC (0x7, gated by flag_c) and JZ (0x8, gated
// by flag_z). Without it those opcodes decode as NOP and the flag inputs are ignored.
module sap_control_sequencer #(
    parameter int OPCODE_W = 4,
    parameter int STEP_W   = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                flag_c,
    input  logic                flag_z,
    output logic                pc_out,
    output logic                pc_inc,
    output logic                pc_load,
    output logic                mar_load,
    output logic                mem_out,
    output logic                ir_load,
    output logic                ir_out,
    output logic                a_load,
    output logic                a_out,
    output logic                b_load,
    output logic                alu_out,
    output logic                alu_sub,
    output logic                out_load,
    output logic [STEP_W-1:0]   step,
    output logic                halted
);

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } step_t;

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    step_t state_q;
    step_t state_d;
    logic  halted_q;
    logic  halted_d;

`ifdef COND_JUMP_EN
    logic  jump_taken;
    assign jump_taken = ((opcode == OP_JC) && flag_c) || ((opcode == OP_JZ) && flag_z);
`else
    logic  unused_flags;
    assign unused_flags = flag_c ^ flag_z;
`endif

    assign step   = STEP_W'(state_q);
    assign halted = halted_q;

    // State register: micro-step and sticky halt, both cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= T0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
        end
    end

    // Next-step selection and control-word decode; strobes forced low in reset and halt.
    always_comb begin
        state_d  = state_q;
        halted_d = halted_q;
        pc_out   = 1'b0;
        pc_inc   = 1'b0;
        pc_load  = 1'b0;
        mar_load = 1'b0;
        mem_out  = 1'b0;
        ir_load  = 1'b0;
        ir_out   = 1'b0;
        a_load   = 1'b0;
        a_out    = 1'b0;
        b_load   = 1'b0;
        alu_out  = 1'b0;
        alu_sub  = 1'b0;
        out_load = 1'b0;

        if (!halted_q) begin
            unique case (state_q)
                T0: begin
                    pc_out   = 1'b1;
                    mar_load = 1'b1;
                    state_d  = T1;
                end
                T1: begin
                    mem_out = 1'b1;
                    ir_load = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = T2;
                end
                T2: begin
                    // Most instructions finish here; multi-step ones override.
                    state_d = T0;
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            ir_out   = 1'b1;
                            mar_load = 1'b1;
                            state_d  = T3;
                        end
                        OP_LDI: begin
                            ir_out = 1'b1;
                            a_load = 1'b1;
                        end
                        OP_JMP: begin
                            ir_out  = 1'b1;
                            pc_load = 1'b1;
                        end
                        OP_OUT: begin
                            a_out    = 1'b1;
                            out_load = 1'b1;
                        end
                        OP_HLT: begin
                            // Freeze at T2 rather than wrapping, so step reads 2 while halted.
                            state_d  = T2;
                            halted_d = 1'b1;
                        end
`ifdef COND_JUMP_EN
                        OP_JC, OP_JZ: begin
                            ir_out  = jump_taken;
                            pc_load = jump_taken;
                        end
`endif
                        default: ;
                    endcase
                end
                T3: begin
                    state_d = T0;
                    if (opcode == OP_LDA) begin
                        mem_out = 1'b1;
                        a_load  = 1'b1;
                    end else if ((opcode == OP_ADD) || (opcode == OP_SUB)) begin
                        mem_out = 1'b1;
                        b_load  = 1'b1;
                        state_d = T4;
                    end
                end
                T4: begin
                    state_d = T0;
                    if ((opcode == OP_ADD) || (opcode == OP_SUB)) begin
                        alu_out = 1'b1;
                        a_load  = 1'b1;
                        alu_sub = (opcode == OP_SUB);
                    end
                end
                default: state_d = T0;
            endcase
        end

        if (rst) begin
            pc_out   = 1'b0;
            pc_inc   = 1'b0;
            pc_load  = 1'b0;
            mar_load = 1'b0;
            mem_out  = 1'b0;
            ir_load  = 1'b0;
            ir_out   = 1'b0;
            a_load   = 1'b0;
            a_out    = 1'b0;
            b_load   = 1'b0;
            alu_out  = 1'b0;
            alu_sub  = 1'b0;
            out_load = 1'b0;
        end
    end

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Testbench for sap_control_sequencer: directed instruction sequences with literal
// expectations, a table-driven instruction model checked every falling edge, and a
// random opcode/flag stream. Honours COND_JUMP_EN the same way the design does.
`timescale 1ns/1ps
module tb_sap_control_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] opcode;
    logic       flag_c, flag_z;
    logic       pc_out, pc_inc, pc_load, mar_load, mem_out, ir_load, ir_out;
    logic       a_load, a_out, b_load, alu_out, alu_sub, out_load;
    logic [2:0] step;
    logic       halted;

    sap_control_sequencer #(.OPCODE_W(4), .STEP_W(3)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .flag_c(flag_c), .flag_z(flag_z),
        .pc_out(pc_out), .pc_inc(pc_inc), .pc_load(pc_load), .mar_load(mar_load),
        .mem_out(mem_out), .ir_load(ir_load), .ir_out(ir_out), .a_load(a_load),
        .a_out(a_out), .b_load(b_load), .alu_out(alu_out), .alu_sub(alu_sub),
        .out_load(out_load), .step(step), .halted(halted)
    );

    always #5 clk = ~clk;

    // Control word bit masks
    localparam logic [12:0] PO = 13'h1000, PI = 13'h0800, PL = 13'h0400, MI = 13'h0200;
    localparam logic [12:0] RO = 13'h0100, II = 13'h0080, IO = 13'h0040, AI = 13'h0020;
    localparam logic [12:0] AO = 13'h0010, BI = 13'h0008, EO = 13'h0004, SU = 13'h0002;
    localparam logic [12:0] OI = 13'h0001;

    logic [12:0] cw;
    assign cw = {pc_out, pc_inc, pc_load, mar_load, mem_out, ir_load, ir_out,
                 a_load, a_out, b_load, alu_out, alu_sub, out_load};

`ifdef COND_JUMP_EN
    localparam logic [12:0] JUMP_CW = IO | PL;
`else
    localparam logic [12:0] JUMP_CW = 13'h0000;
`endif

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Instruction model: per-opcode micro-program table and last-step index
    logic [12:0] prog [16][5];
    int          last_step [16];
    int          m_step = 0;
    bit          m_halted = 1'b0;

    initial begin
        for (int op = 0; op < 16; op++) begin
            for (int s = 0; s < 5; s++) prog[op][s] = 13'h0;
            prog[op][0]   = PO | MI;
            prog[op][1]   = RO | II | PI;
            last_step[op] = 2;
        end
        prog[1][2] = IO | MI;  prog[1][3] = RO | AI;  last_step[1] = 3;
        for (int op = 2; op < 4; op++) begin
            prog[op][2]   = IO | MI;
            prog[op][3]   = RO | BI;
            prog[op][4]   = EO | AI | ((op == 3) ? SU : 13'h0);
            last_step[op] = 4;
        end
        prog[5][2]  = IO | AI;
        prog[6][2]  = IO | PL;
        prog[14][2] = AO | OI;
        prog[7][2]  = JUMP_CW;
        prog[8][2]  = JUMP_CW;
    end

    function automatic logic [12:0] exp_cw();
        if (rst || m_halted) return 13'h0;
        if (m_step == 2 && opcode == 4'h7 && !flag_c) return 13'h0;
        if (m_step == 2 && opcode == 4'h8 && !flag_z) return 13'h0;
        return prog[opcode][m_step];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_step   = 0;
            m_halted = 1'b0;
        end else if (!m_halted) begin
            if (m_step == 2 && opcode == 4'hF) m_halted = 1'b1;
            else if (m_step >= last_step[opcode]) m_step = 0;
            else m_step = m_step + 1;
        end
    end

    bit cmp_en = 1'b0;

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_cw", cw, exp_cw());
            chk("model_step", step, m_step[2:0]);
            chk("model_halted", halted, m_halted);
            chk("bus_onehot", ($countones({pc_out, mem_out, ir_out, a_out, alu_out}) <= 1), 1);
            chk("step_range", (step <= 3'd4), 1);
        end
    end

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    int nop_seq [4] = '{1, 2, 0, 1};

    initial begin
        rst = 1'b1; opcode = 4'h0; flag_c = 1'b0; flag_z = 1'b0;
        @(posedge clk); #1;
        cmp_en = 1'b1;
        chk("rst_step", step, 0);
        chk("rst_halted", halted, 0);
        chk("rst_cw", cw, 0);

        // NOP stream after reset: steps 0,1,2,0,1
        @(posedge clk); #2; rst = 1'b0; #1;
        chk("t0_cw", cw, PO | MI);
        chk("t0_step", step, 0);
        for (int i = 0; i < 4; i++) begin
            adv();
            chk("nop_step", step, nop_seq[i]);
            if (i == 0) chk("t1_cw", cw, RO | II | PI);
        end
        opcode = 4'h2; #1;
        chk("fetch_ignores_opcode", cw, RO | II | PI);

        // ADD then SUB
        adv(); chk("add_t2", cw, IO | MI);   chk("add_t2_step", step, 2);
        adv(); chk("add_t3", cw, RO | BI);   chk("add_t3_step", step, 3);
        adv(); chk("add_t4", cw, EO | AI);   chk("add_t4_step", step, 4);
        adv(); chk("add_wrap", step, 0);     chk("add_wrap_cw", cw, PO | MI);
        adv(); opcode = 4'h3;
        adv(); chk("sub_t2", cw, IO | MI);
        adv(); chk("sub_t3", cw, RO | BI);
        adv(); chk("sub_t4", cw, EO | AI | SU);
        adv(); chk("sub_wrap", step, 0);

        // HLT: freezes at step 2 with all strobes low until reset
        opcode = 4'hF;
        adv(); adv();
        chk("hlt_t2_cw", cw, 0); chk("hlt_t2_halted", halted, 0); chk("hlt_t2_step", step, 2);
        adv();
        chk("hlt_halted", halted, 1); chk("hlt_step", step, 2);
        for (int i = 0; i < 10; i++) begin
            adv();
            chk("hlt_hold_step", step, 2);
            chk("hlt_hold_cw", cw, 0);
        end
        rst = 1'b1; #2;
        chk("hlt_rst_step", step, 0); chk("hlt_rst_halted", halted, 0);
        rst = 1'b0;

        // LDA with asynchronous reset in the middle of T3
        opcode = 4'h1;
        adv(); adv(); chk("lda_t2", cw, IO | MI);
        adv(); chk("lda_t3", cw, RO | AI);
        #2; rst = 1'b1; #1;
        chk("async_rst_cw", cw, 0); chk("async_rst_step", step, 0);
        #3; rst = 1'b0;
        adv(); chk("post_rst_step", step, 1); chk("post_rst_cw", cw, RO | II | PI);

        // Conditional jumps (NOP when the feature is absent)
        opcode = 4'h8; flag_z = 1'b1;
        adv(); chk("jz_taken", cw, JUMP_CW); chk("jz_step", step, 2);
        adv(); chk("jz_wrap", step, 0);
        adv(); flag_z = 1'b0;
        adv(); chk("jz_not_taken", cw, 0);
        adv(); chk("jz_nt_wrap", step, 0);
        adv(); opcode = 4'h7; flag_c = 1'b1; flag_z = 1'b0;
        adv(); chk("jc_taken", cw, JUMP_CW);
        adv(); chk("jc_wrap", step, 0);

        // Random opcode/flag stream; opcode only changes during fetch
        for (int i = 0; i < 1000; i++) begin
            adv();
            if (m_step < 2) opcode = 4'($urandom_range(0, 15));
            flag_c = 1'($urandom_range(0, 1));
            flag_z = 1'($urandom_range(0, 1));
            if (m_halted && $urandom_range(0, 3) == 0) begin
                rst = 1'b1; #2; rst = 1'b0;
            end
        end

        adv();
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
